stream_sampler: RTL and testbench

//  Logic-analyzer capture stage between the input stream (sample data + trigger flag) and the capture buffer.

---
 rtl/stream_sampler.sv | 102 ++++++++++
 tb/tb_stream_sampler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sampler.sv
// Logic-analyzer capture stage: decimates an armed input stream, forwards a fixed number
// of samples after the first trigger, marks the final one with tlast and then disarms.
module stream_sampler #(
    parameter int SDW = 32,
    parameter int SCW = 32,
    parameter int SNW = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ctl_st0,
    input  logic           ctl_st1,
    input  logic [SCW-1:0] cfg_div,
    input  logic [SNW-1:0] cfg_num,
    output logic           sts_run,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sti_tvalid,
    input  logic           sti_trigger,
    output logic           sti_tready,
    output logic [SDW-1:0] sto_tdata,
    output logic           sto_tvalid,
    output logic           sto_trigger,
    output logic           sto_tlast,
    input  logic           sto_tready
);

    logic [SCW-1:0] dec_cnt;
    logic [SNW-1:0] post_cnt;
    logic [SNW-1:0] post_next;
    logic           trig_pend;
    logic           triggered;
    logic           xfer;
    logic           emit;
    logic           trig_in;
    logic           first_trig;
    logic           last;

    always_comb begin
        sti_tready = sts_run ? (~sto_tvalid | sto_tready) : 1'b1;
        xfer       = sti_tvalid & sti_tready;
        emit       = sts_run & xfer & (dec_cnt == '0);
        trig_in    = sti_trigger | trig_pend;
        first_trig = trig_in & ~triggered;
        post_next  = post_cnt + 1'b1;
        // Only the first trigger of a capture starts the post-trigger count.
        if (first_trig)
            last = (cfg_num == '0);
        else
            last = triggered & (post_next == cfg_num);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sts_run     <= 1'b1;
            dec_cnt     <= '0;
            post_cnt    <= '0;
            trig_pend   <= 1'b0;
            triggered   <= 1'b0;
            sto_tdata   <= '0;
            sto_tvalid  <= 1'b0;
            sto_trigger <= 1'b0;
            sto_tlast   <= 1'b0;
        end else begin
            if (sto_tvalid && sto_tready)
                sto_tvalid <= 1'b0;

            if (sts_run && xfer) begin
                if (emit) begin
                    sto_tdata   <= sti_tdata;
                    sto_tvalid  <= 1'b1;
                    sto_trigger <= trig_in;
                    sto_tlast   <= last;
                    trig_pend   <= 1'b0;
                    dec_cnt     <= cfg_div;
                    if (first_trig) begin
                        triggered <= 1'b1;
                        post_cnt  <= '0;
                    end else if (triggered) begin
                        post_cnt  <= post_next;
                    end
                    if (last)
                        sts_run <= 1'b0;
                end else begin
                    dec_cnt <= dec_cnt - 1'b1;
                    if (sti_trigger)
                        trig_pend <= 1'b1;
                end
            end

            // Stop outranks start when both pulse together.
            if (ctl_st0) begin
                sts_run <= 1'b0;
            end else if (ctl_st1) begin
                sts_run   <= 1'b1;
                dec_cnt   <= '0;
                post_cnt  <= '0;
                triggered <= 1'b0;
                trig_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_sampler.sv
// Scoreboard bench for stream_sampler: a behavioural model queues expected outputs as
// inputs are accepted; a monitor pops and compares on every output handshake.
module tb_stream_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ctl_st0 = 1'b0;
    logic        ctl_st1 = 1'b0;
    logic [31:0] cfg_div = '0;
    logic [31:0] cfg_num = '0;
    logic        sts_run;
    logic [31:0] sti_tdata = '0;
    logic        sti_tvalid = 1'b0;
    logic        sti_trigger = 1'b0;
    logic        sti_tready;
    logic [31:0] sto_tdata;
    logic        sto_tvalid;
    logic        sto_trigger;
    logic        sto_tlast;
    logic        sto_tready = 1'b1;

    always #5 clk = ~clk;

    stream_sampler #(.SDW(32), .SCW(32), .SNW(32)) dut (
        .clk(clk), .rst(rst), .ctl_st0(ctl_st0), .ctl_st1(ctl_st1),
        .cfg_div(cfg_div), .cfg_num(cfg_num), .sts_run(sts_run),
        .sti_tdata(sti_tdata), .sti_tvalid(sti_tvalid), .sti_trigger(sti_trigger),
        .sti_tready(sti_tready), .sto_tdata(sto_tdata), .sto_tvalid(sto_tvalid),
        .sto_trigger(sto_trigger), .sto_tlast(sto_tlast), .sto_tready(sto_tready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        trig;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    bit   m_run = 1'b1;
    int   m_phase = 0;
    bit   m_pend = 1'b0;
    bit   m_trigd = 1'b0;
    int   m_left = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b1; m_phase = 0; m_pend = 1'b0; m_trigd = 1'b0; m_left = 0;
    endtask

    task automatic model_accept(input logic [31:0] d, input logic tr);
        exp_t e;
        bit   t;
        bit   l;
        if (!m_run) return;
        if (m_phase == 0) begin
            t = tr | m_pend;
            l = 1'b0;
            if (t && !m_trigd) begin
                m_trigd = 1'b1;
                m_left  = int'(cfg_num);
                l       = (m_left == 0);
            end else if (m_trigd) begin
                m_left--;
                l = (m_left == 0);
            end
            e.data = d; e.trig = t; e.last = l;
            q.push_back(e);
            m_pend = 1'b0;
            if (l) m_run = 1'b0;
        end else if (tr) begin
            m_pend = 1'b1;
        end
        m_phase = (m_phase >= int'(cfg_div)) ? 0 : m_phase + 1;
    endtask

    // Called at posedge+1; returns at the next posedge+1 after the transfer.
    task automatic send(input logic [31:0] d, input logic tr, output int waits);
        bit ok;
        sti_tdata = d; sti_trigger = tr; sti_tvalid = 1'b1;
        waits = 0; ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            if (sti_tready) ok = 1'b1;
            else begin
                waits++;
                if (waits > 50) begin
                    chk("send_timeout", 64'd1, 64'd0);
                    break;
                end
            end
        end
        if (ok) begin
            @(posedge clk);
            model_accept(d, tr);
        end
        #1;
        sti_tvalid = 1'b0; sti_trigger = 1'b0;
    endtask

    task automatic send_range(input int first, input int n, input int trig_at);
        int w;
        for (int i = first; i < first + n; i++)
            send(32'(i), (i == trig_at), w);
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while ((q.size() != 0 || sto_tvalid) && c < 100) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk); #1;
        chk({"drain_", tag}, 64'(q.size()), 64'd0);
    endtask

    task automatic pulse_start();
        ctl_st1 = 1'b1;
        @(posedge clk); #1;
        ctl_st1 = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && sto_tvalid && sto_tready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {32'd0, sto_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("out_data", 64'(sto_tdata), 64'(e.data));
                chk("out_trig", 64'(sto_trigger), 64'(e.trig));
                chk("out_last", 64'(sto_tlast), 64'(e.last));
            end
        end
    end

    initial begin
        int          w;
        logic [31:0] held;

        #12;
        chk("rst_tvalid", 64'(sto_tvalid), 64'd0);
        chk("rst_tdata", 64'(sto_tdata), 64'd0);
        chk("rst_run", 64'(sts_run), 64'd1);
        chk("rst_tready", 64'(sti_tready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Pass-through, no trigger
        cfg_div = 0; cfg_num = 4;
        send_range(0, 8, -1);
        drain("pass");
        chk("pass_run", 64'(sts_run), 64'd1);

        // Decimate by 4; dropped samples never stall
        pulse_start();
        cfg_div = 3;
        for (int i = 0; i < 16; i++) begin
            send(32'(i), 1'b0, w);
            chk("dec_nowait", 64'(w), 64'd0);
        end
        drain("dec");

        // Output back-pressure for 5 cycles
        pulse_start();
        cfg_div = 0;
        fork
            send_range(100, 10, -1);
            begin
                repeat (3) @(posedge clk);
                #1 sto_tready = 1'b0;
                @(negedge clk);
                held = sto_tdata;
                chk("stall_valid", 64'(sto_tvalid), 64'd1);
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_tready", 64'(sti_tready), 64'd0);
                    chk("stall_hold", 64'(sto_tdata), 64'(held));
                end
                @(posedge clk); #1 sto_tready = 1'b1;
            end
        join
        drain("stall");

        // Trigger on 5, two more samples, then disarm
        pulse_start();
        cfg_div = 0; cfg_num = 2;
        send_range(0, 8, 5);
        drain("trig");
        chk("trig_run", 64'(sts_run), 64'(m_run));
        chk("trig_run0", 64'(sts_run), 64'd0);
        send_range(8, 3, -1);
        drain("trig_discard");

        // Trigger on a dropped sample is carried to the next emitted one
        pulse_start();
        cfg_div = 1; cfg_num = 1;
        send_range(0, 8, 3);
        drain("pend");
        chk("pend_run", 64'(sts_run), 64'd0);

        // Stop mid-stream, then restart with a new divider
        pulse_start();
        cfg_div = 0; cfg_num = 10;
        send_range(0, 3, -1);
        ctl_st0 = 1'b1;
        @(posedge clk); #1;
        ctl_st0 = 1'b0;
        m_run = 1'b0;
        chk("stop_run", 64'(sts_run), 64'd0);
        send_range(3, 3, -1);
        drain("stop");
        pulse_start();
        chk("start_run", 64'(sts_run), 64'd1);
        cfg_div = 2;
        send_range(10, 4, -1);
        drain("restart");

        // Asynchronous reset drops a held output
        pulse_start();
        cfg_div = 0;
        sto_tready = 1'b0;
        send(32'd99, 1'b0, w);
        chk("prerst_valid", 64'(sto_tvalid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(sto_tvalid), 64'd0);
        chk("arst_data", 64'(sto_tdata), 64'd0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        sto_tready = 1'b1;
        model_reset();
        chk("arst_run", 64'(sts_run), 64'd1);
        cfg_div = 1;
        send_range(20, 3, -1);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
